// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result bundle for seq_divider (dbz present with SEQ_DIV_DBZ_EN)
interface seq_divider_if #(parameter int n = 8);
  logic start;
  logic [n-1:0] dividend;
  logic [n-1:0] divisor;
  logic [n-1:0] quotient;
  logic [n-1:0] remainder;
  logic valid;
`ifdef SEQ_DIV_DBZ_EN
  logic dbz;
  modport master (output start, dividend, divisor, input quotient, remainder, valid, dbz);
  modport slave (input start, dividend, divisor, output quotient, remainder, valid, dbz);
`else
  modport master (output start, dividend, divisor, input quotient, remainder, valid);
  modport slave (input start, dividend, divisor, output quotient, remainder, valid);
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock; SEQ_DIV_DBZ_EN adds a 1-edge divide-by-zero path
module bit8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo, h0, h1;
  assign lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign h0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign h1 = h0 + 5'd1;
  assign {cout, s} = {lo[4] ? h1 : h0, lo[3:0]};
endmodule

module seq_divider #(parameter int n = 8) (
  input logic clock,
  input logic reset,
  seq_divider_if.slave bus
);
  localparam int cw = $clog2(n + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [n:0] r, r_n, t, d;
  logic [n-1:0] q, q_n, dv, dv_n, dd, dd_n, quo, quo_n, rem, rem_n;
  logic [cw-1:0] count, count_n;
  logic vld, vld_n;
  logic [7:0] s;
  logic c8, co;
`ifdef SEQ_DIV_DBZ_EN
  logic dz, dz_n;
  assign bus.dbz = dz;
`endif
  assign t = {r[n-1:0], q[n-1]};
  bit8 u_add (.a(t[7:0]), .b(~dv[7:0]), .cin(1'b1), .s(s), .cout(c8));
  // top stage adds t[n] to the inverted zero msb of the divisor
  assign co = t[n] | c8;
  assign d = {~(t[n] ^ c8), s};
  always_comb begin
    state_n = state;
    r_n = r;
    q_n = q;
    dv_n = dv;
    dd_n = dd;
    quo_n = quo;
    rem_n = rem;
    count_n = count;
    vld_n = vld;
`ifdef SEQ_DIV_DBZ_EN
    dz_n = dz;
`endif
    if (!bus.start) begin
      state_n = IDLE;
      r_n = '0;
      q_n = '0;
      dv_n = '0;
      dd_n = '0;
      quo_n = '0;
      rem_n = '0;
      count_n = '0;
      vld_n = 1'b0;
`ifdef SEQ_DIV_DBZ_EN
      dz_n = 1'b0;
`endif
    end else if (state == IDLE) begin
      dd_n = bus.dividend;
      dv_n = bus.divisor;
      q_n = bus.dividend;
      r_n = '0;
      count_n = cw'(n);
      state_n = CALC;
`ifdef SEQ_DIV_DBZ_EN
      if (bus.divisor == '0) begin
        state_n = DONE;
        quo_n = '1;
        rem_n = bus.dividend;
        vld_n = 1'b1;
        dz_n = 1'b1;
      end
`endif
    end else if (state == CALC) begin
      r_n = co ? d : t;
      q_n = {q[n-2:0], co};
      count_n = count - 1'b1;
      if (count == cw'(1)) begin
        quo_n = q_n;
        rem_n = r_n[n-1:0];
        vld_n = 1'b1;
        state_n = DONE;
      end
    end else if (bus.dividend != dd || bus.divisor != dv) begin
      quo_n = '0;
      rem_n = '0;
      vld_n = 1'b0;
      state_n = IDLE;
`ifdef SEQ_DIV_DBZ_EN
      dz_n = 1'b0;
`endif
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      dv <= '0;
      dd <= '0;
      quo <= '0;
      rem <= '0;
      count <= '0;
      vld <= 1'b0;
`ifdef SEQ_DIV_DBZ_EN
      dz <= 1'b0;
`endif
    end else begin
      state <= state_n;
      r <= r_n;
      q <= q_n;
      dv <= dv_n;
      dd <= dd_n;
      quo <= quo_n;
      rem <= rem_n;
      count <= count_n;
      vld <= vld_n;
`ifdef SEQ_DIV_DBZ_EN
      dz <= dz_n;
`endif
    end
  end
  assign bus.quotient = quo;
  assign bus.remainder = rem;
  assign bus.valid = vld;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a scoreboard of expected results and edge of arrival
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic pv = 1'b0;
  typedef struct {
    int q;
    int r;
    int z;
    int c;
  } exp_t;
  exp_t sb[$];
  exp_t held;
  seq_divider_if #(.n(8)) bus ();
  seq_divider #(.n(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef SEQ_DIV_DBZ_EN
  localparam int zlat = 1;
  localparam int zflag = 1;
  function automatic int dbz_now();
    return int'(bus.dbz);
  endfunction
`else
  localparam int zlat = 9;
  localparam int zflag = 0;
  function automatic int dbz_now();
    return 0;
  endfunction
`endif
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask
  task automatic push(input int q, input int r, input int z, input int lat);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    e.c = cyc + lat;
    sb.push_back(e);
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (bus.valid && !pv) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", int'(bus.quotient), e.q);
        chk("remainder", int'(bus.remainder), e.r);
        chk("dbz", dbz_now(), e.z);
        chk("latency_edge", cyc, e.c);
        held = e;
      end
    end else if (bus.valid) begin
      chk("hold_quotient", int'(bus.quotient), held.q);
      chk("hold_remainder", int'(bus.remainder), held.r);
    end else begin
      chk("idle_quotient", int'(bus.quotient), 0);
      chk("idle_remainder", int'(bus.remainder), 0);
      chk("idle_dbz", dbz_now(), 0);
    end
    pv = bus.valid;
  end
  task automatic run(input int a, input int b, input int eq, input int er, input int ez, input int lat);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.dividend = 8'(a);
    bus.divisor = 8'(b);
    bus.start = 1'b1;
    push(eq, er, ez, lat);
    repeat (lat + 3) @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_quotient", int'(bus.quotient), 0);
    rst = 1'b0;
    bus.dividend = 8'd200;
    bus.divisor = 8'd3;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_reset_valid", int'(bus.valid), 0);
    rst = 1'b0;
    push(66, 2, 0, 9);
    repeat (12) @(negedge clk);
    run(100, 7, 14, 2, 0, 9);
    bus.dividend = 8'd50;
    push(7, 1, 0, 10);
    @(negedge clk);
    chk("change_drops_valid", int'(bus.valid), 0);
    repeat (12) @(negedge clk);
    run(255, 1, 255, 0, 0, 9);
    run(5, 9, 0, 5, 0, 9);
    run(255, 255, 1, 0, 0, 9);
    run(0, 5, 0, 0, 0, 9);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.dividend = 8'd200;
    bus.divisor = 8'd3;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_start_valid", int'(bus.valid), 0);
    bus.start = 1'b1;
    push(66, 2, 0, 9);
    repeat (11) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    bus.start = 1'b1;
    push(14, 2, 0, 9);
    repeat (3) @(negedge clk);
    bus.dividend = 8'd1;
    bus.divisor = 8'd1;
    repeat (2) @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    repeat (7) @(negedge clk);
    run(13, 0, 255, 13, zflag, zlat);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring shift-subtract divider: the inverse datapath of the 8-bit shift-add sequential multiplier. It divides an n-bit unsigned dividend by an n-bit unsigned divisor, producing one quotient bit per clock. It uses the same level-held `start` and `valid` handshake as the multiplier, so both blocks share one controller in the arithmetic unit. The subtract step reuses the `bit8` carry-select adder.

## Interface
- `n`, 8, operand width. The adder path is built for n=8.
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level-held request; low acts as a synchronous clear.
- `dividend`  in  n  unsigned dividend.
- `divisor`  in  n  unsigned divisor.
- `quotient`  out  n  result quotient.
- `remainder`  out  n  result remainder.
- `valid`  out  1  result valid; high while the result is held.
- `dbz`  out  1  divide-by-zero flag. Present only with `SEQ_DIV_DBZ_EN`.

## Operation
- Internal state:
  - `r`: remainder register, n+1 bits.
  - `q`: quotient/dividend shift register, n bits.
  - `dv`: latched divisor, n bits.
  - `dd`: latched dividend, n bits.
  - `count`: step counter, 0..n.
- Clear condition is `reset==1` or `start==0`. At the next edge:
  - state goes to IDLE;
  - `r`, `q`, `dv`, `dd`, `count`, `quotient`, `remainder`, `valid` and `dbz` all go to 0.
- IDLE, with `start=1`:
  - latch `dd`=dividend and `dv`=divisor;
  - set `q`=dividend, `r`=0, `count`=n;
  - go to CALC.
- CALC, one step per cycle:
  - `t` = {r[n-1:0], q[n-1]}.
  - `d` = `t` + ~{1'b0,dv} + 1. The low 8 bits come from `bit8` with cin=1; a 1-bit top stage completes it.
  - If the top stage carries out (no borrow): `r`=`d`[n:0], `q`={q[n-2:0],1}. Otherwise: `r`=`t`, `q`={q[n-2:0],0}.
  - `count` decrements each step.
  - On the step where `count`==1: `quotient` gets the final `q`, `remainder` gets the final `r`[n-1:0], `valid` goes to 1, and state goes to DONE.
- DONE:
  - If dividend==`dd` and divisor==`dv`: hold all outputs and stay.
  - Otherwise: drop `valid` and clear `quotient`/`remainder` to 0, go to IDLE, and relaunch on the next edge if `start` is still high.
- Between IDLE and DONE, `quotient` and `remainder` read 0. Intermediate values are never exposed.
- Input changes during CALC are ignored. The latched operands are used.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `valid`=0, `dbz`=0.
- Edge 1 is the first rising edge with `start`=1 in IDLE; it latches the operands.
- CALC steps occur at edges 2..n+1. `valid` is sampled high after edge n+1, so latency is n+1 edges (9 for n=8).
- Reset or `start` low has priority over every state, including mid-CALC. It aborts at that edge and no result is produced.
- Operand change in DONE: `valid` falls at the next edge. The new result is valid n+2 edges after that change is sampled.
- Back-to-back operations need no idle gap beyond the mandatory IDLE cycle.

## Configuration
- `SEQ_DIV_DBZ_EN` defined:
  - `dbz` port exists.
  - IDLE with `start`=1 and divisor==0 goes directly to DONE at edge 1.
  - Outputs are then `quotient`={n{1'b1}}, `remainder`=dividend, `valid`=1, `dbz`=1. Latency is 1 edge.
  - `dbz` is 0 for every nonzero divisor and is cleared like `valid`.
- Undefined:
  - No `dbz` port.
  - A zero divisor runs the normal n-step sequence.
  - The natural restoring result is `quotient`={n{1'b1}}, `remainder`=dividend, with `valid` at edge n+1.

## Test plan
- Reset while `start`=1 mid-CALC → next edge: `quotient`=0, `remainder`=0, `valid`=0; after `reset` falls, a fresh start has full n+1 latency.
- 100/7, `start` held → `valid`=1 after edge 9, `quotient`=14, `remainder`=2.
- 255/1, 5/9, and 255/255 → (255,0), (0,5), (1,0). Each is stable in DONE while operands are held.
- `start` dropped after edge 4 of 200/3 → next edge all outputs 0, state IDLE. Re-raising `start` gives 66 r 2 after 9 more edges.
- In DONE for 100/7, change dividend to 50 → `valid` 0 at next edge; `quotient`=7, `remainder`=1 valid 10 edges after the change.
- 13/0 → with `SEQ_DIV_DBZ_EN`: edge 1 gives `valid`=1, `dbz`=1, `quotient`=255, `remainder`=13. Without the macro: same values at edge 9 and no `dbz` port.
